// File: rtl/systolic_stream_deser_pkg.sv
// Shared constants and the queued-entry layout for the systolic tile
// nibble-stream deserializer.
package systolic_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 16;
    localparam int BEATS  = 4;

    localparam logic [1:0] TAG_PASS0  = 2'd0;
    localparam logic [1:0] TAG_PASS1  = 2'd1;
    localparam logic [1:0] TAG_ACC_LO = 2'd2;
    localparam logic [1:0] TAG_ACC_HI = 2'd3;

    localparam logic LANE_COL = 1'b0;
    localparam logic LANE_ROW = 1'b1;

    typedef struct packed {
        logic              lane;
        logic [1:0]        tag;
        logic [WORD_W-1:0] data;
    } deser_entry_t;

    // Accumulator readback frames carry tag 2 or 3.
    function automatic logic tag_is_readback(input logic [1:0] tag);
        return (tag >= TAG_ACC_LO);
    endfunction

endpackage

// File: rtl/systolic_stream_deser_fifo2w.sv
// Two-write / one-read first-word-fall-through FIFO. The caller guarantees
// that writes never exceed the free space; wr1 is only used together with wr0.
module systolic_fifo2w
    import systolic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr0_en,
    input  deser_entry_t             wr0_data,
    input  logic                     wr1_en,
    input  deser_entry_t             wr1_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output deser_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    deser_entry_t  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr_p1;
    logic          pop;

    assign wptr_p1  = wptr + AW'(1);
    assign rd_valid = (count != '0);
    assign pop      = rd_en && rd_valid;
    // Empty FIFO presents zeros rather than stale storage.
    assign rd_data  = rd_valid ? mem[rptr] : '0;

    // Storage writes; slot for wr1 follows the wr0 slot.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wptr] <= wr0_data;
        if (wr1_en) mem[wptr_p1] <= wr1_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(wr0_en) + AW'(wr1_en);
            rptr  <= rptr + AW'(pop);
            count <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);
        end
    end

endmodule

// File: rtl/systolic_stream_deser.sv
// Reassembles the tile's column/row nibble streams into 16-bit words with a
// 2-bit tag, filters them, and queues them for a valid/ready host port.
// Optional feature macro: SYSTOLIC_DESER_ALIGN_CHECK_EN (frame alignment
// checker driving align_err; tied low when undefined).
module systolic_stream_deser #(
    parameter int DEPTH     = 4,
    parameter bit KEEP_PASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        frame_sync,
    input  logic [3:0]  col_nib,
    input  logic        col_ctrl,
    input  logic [3:0]  row_nib,
    input  logic        row_ctrl,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_lane,
    output logic [1:0]  out_tag,
    input  logic        clr_flags,
    output logic        overflow,
    output logic        align_err
);

    import systolic_pkg::*;

    localparam int PW = $clog2(BEATS);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]         phase;
    logic                  synced;
    logic [3*NIB_W-1:0]    col_shift;
    logic [3*NIB_W-1:0]    row_shift;
    logic [2:0]            col_cshift;
    logic [2:0]            row_cshift;

    logic                  frame_done;
    deser_entry_t          col_entry;
    deser_entry_t          row_entry;
    logic                  col_keep;
    logic                  row_keep;
    logic                  pop;
    logic [CW-1:0]         fifo_count;
    logic [CW:0]           free_slots;
    logic                  wr0_en;
    logic                  wr1_en;
    deser_entry_t          wr0_data;
    deser_entry_t          wr1_data;
    logic                  drop;
    deser_entry_t          head;

    // A frame completes on the fourth beat only when it was not restarted
    // by frame_sync on that same beat.
    assign frame_done = en && synced && !frame_sync && (phase == PW'(BEATS - 1));

    // ctrl[3:2] of the frame sit at cshift[2:1] when the last beat arrives.
    assign col_entry = '{lane: LANE_COL, tag: col_cshift[2:1], data: {col_shift, col_nib}};
    assign row_entry = '{lane: LANE_ROW, tag: row_cshift[2:1], data: {row_shift, row_nib}};

    assign col_keep = frame_done && (KEEP_PASS || tag_is_readback(col_entry.tag));
    assign row_keep = frame_done && (KEEP_PASS || tag_is_readback(row_entry.tag));

    assign pop        = out_valid && out_ready;
    assign free_slots = (CW+1)'(DEPTH) - {1'b0, fifo_count} + {{CW{1'b0}}, pop};

    // Beat phase, sync state and MSB-first nibble/ctrl shift registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            synced     <= 1'b0;
            col_shift  <= '0;
            row_shift  <= '0;
            col_cshift <= '0;
            row_cshift <= '0;
        end else if (en) begin
            phase      <= frame_sync ? PW'(1) : phase + PW'(1);
            if (frame_sync) synced <= 1'b1;
            col_shift  <= {col_shift[2*NIB_W-1:0], col_nib};
            row_shift  <= {row_shift[2*NIB_W-1:0], row_nib};
            col_cshift <= {col_cshift[1:0], col_ctrl};
            row_cshift <= {row_cshift[1:0], row_ctrl};
        end
    end

    // Admission: column word takes priority when only one slot is free.
    always_comb begin
        wr0_en   = 1'b0;
        wr1_en   = 1'b0;
        wr0_data = col_entry;
        wr1_data = row_entry;
        drop     = 1'b0;
        if (col_keep && row_keep) begin
            if (free_slots >= (CW+1)'(2)) begin
                wr0_en = 1'b1;
                wr1_en = 1'b1;
            end else if (free_slots == (CW+1)'(1)) begin
                wr0_en = 1'b1;
                drop   = 1'b1;
            end else begin
                drop   = 1'b1;
            end
        end else if (col_keep || row_keep) begin
            wr0_data = col_keep ? col_entry : row_entry;
            if (free_slots != '0) wr0_en = 1'b1;
            else                  drop   = 1'b1;
        end
    end

    systolic_fifo2w #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (out_ready),
        .rd_valid (out_valid),
        .rd_data  (head),
        .count    (fifo_count)
    );

    assign out_data = head.data;
    assign out_lane = head.lane;
    assign out_tag  = head.tag;

    // Sticky overflow; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (clr_flags) overflow <= 1'b0;
    end

`ifdef SYSTOLIC_DESER_ALIGN_CHECK_EN
    logic align_set;

    // Sync arriving off beat 0, or a beat 0 arriving without sync.
    assign align_set = en && synced &&
                       (frame_sync ? (phase != '0) : (phase == '0));

    // Sticky alignment error; set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         align_err <= 1'b0;
        else if (align_set) align_err <= 1'b1;
        else if (clr_flags) align_err <= 1'b0;
    end
`else
    assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_stream_deser.sv
// Bench for systolic_stream_deser: two instances (KEEP_PASS=1 and 0) share
// one randomized stimulus stream and are compared every cycle against a
// queue-based frame model, plus directed literal checks.
module tb_systolic_stream_deser;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        frame_sync = 1'b0;
    logic [3:0]  col_nib = '0;
    logic        col_ctrl = 1'b0;
    logic [3:0]  row_nib = '0;
    logic        row_ctrl = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_flags = 1'b0;

    logic        out_valid_k, out_lane_k, overflow_k, align_err_k;
    logic [15:0] out_data_k;
    logic [1:0]  out_tag_k;
    logic        out_valid_f, out_lane_f, overflow_f, align_err_f;
    logic [15:0] out_data_f;
    logic [1:0]  out_tag_f;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 1'b1;

    always #5 clk = ~clk;

    systolic_stream_deser #(.DEPTH(DEPTH), .KEEP_PASS(1'b1)) dut_k (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_sync(frame_sync),
        .col_nib(col_nib), .col_ctrl(col_ctrl), .row_nib(row_nib), .row_ctrl(row_ctrl),
        .out_valid(out_valid_k), .out_ready(out_ready), .out_data(out_data_k),
        .out_lane(out_lane_k), .out_tag(out_tag_k), .clr_flags(clr_flags),
        .overflow(overflow_k), .align_err(align_err_k)
    );

    systolic_stream_deser #(.DEPTH(DEPTH), .KEEP_PASS(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_sync(frame_sync),
        .col_nib(col_nib), .col_ctrl(col_ctrl), .row_nib(row_nib), .row_ctrl(row_ctrl),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_data(out_data_f),
        .out_lane(out_lane_f), .out_tag(out_tag_f), .clr_flags(clr_flags),
        .overflow(overflow_f), .align_err(align_err_f)
    );

    // ---------------- behavioural model ----------------
    // Queue entries are {lane, tag[1:0], data[15:0]}.
    logic [18:0] mq0[$];
    logic [18:0] mq1[$];
    bit          m_ov0, m_ov1, m_al;
    bit          m_synced;
    int          m_beat;          // beats received in the current frame
    int          cn[4], rn[4];
    bit          cc[4], rc[4];
    int          m_idx, m_free, m_word;
    bit          m_done, m_ovs0, m_ovs1, m_als;
    logic [1:0]  m_tag;
    logic [18:0] m_ent;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq0.delete();
            mq1.delete();
            m_ov0 = 0; m_ov1 = 0; m_al = 0;
            m_synced = 0; m_beat = 0;
        end else begin
            m_done = 0; m_ovs0 = 0; m_ovs1 = 0; m_als = 0;
            if (out_ready && mq0.size() > 0) void'(mq0.pop_front());
            if (out_ready && mq1.size() > 0) void'(mq1.pop_front());
            if (en) begin
                if (m_synced && (frame_sync ? (m_beat % 4 != 0) : (m_beat % 4 == 0)))
                    m_als = 1;
                if (frame_sync || m_synced) begin
                    m_idx = frame_sync ? 0 : m_beat % 4;
                    cn[m_idx] = int'(col_nib); cc[m_idx] = col_ctrl;
                    rn[m_idx] = int'(row_nib); rc[m_idx] = row_ctrl;
                    m_done   = (m_idx == 3);
                    m_beat   = m_idx + 1;
                    m_synced = 1;
                end
            end
            if (m_done) begin
                for (int i = 0; i < 2; i++) begin
                    m_free = DEPTH - ((i == 0) ? mq0.size() : mq1.size());
                    for (int l = 0; l < 2; l++) begin
                        m_word = (l == 0) ? cn[0]*4096 + cn[1]*256 + cn[2]*16 + cn[3]
                                          : rn[0]*4096 + rn[1]*256 + rn[2]*16 + rn[3];
                        m_tag  = (l == 0) ? {cc[0], cc[1]} : {rc[0], rc[1]};
                        m_ent  = {l[0], m_tag, m_word[15:0]};
                        if (i == 0 || m_tag >= 2'd2) begin
                            if (m_free > 0) begin
                                if (i == 0) mq0.push_back(m_ent);
                                else        mq1.push_back(m_ent);
                                m_free--;
                            end else if (i == 0) m_ovs0 = 1;
                            else                 m_ovs1 = 1;
                        end
                    end
                end
            end
            m_ov0 = m_ovs0 ? 1'b1 : (clr_flags ? 1'b0 : m_ov0);
            m_ov1 = m_ovs1 ? 1'b1 : (clr_flags ? 1'b0 : m_ov1);
`ifdef SYSTOLIC_DESER_ALIGN_CHECK_EN
            m_al  = m_als ? 1'b1 : (clr_flags ? 1'b0 : m_al);
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    logic [21:0] exp_k, exp_f, act_k, act_f;
    always @(negedge clk) begin
        if (chk_on) begin
            exp_k = {mq0.size() != 0, (mq0.size() != 0) ? mq0[0] : 19'd0, m_ov0, m_al};
            exp_f = {mq1.size() != 0, (mq1.size() != 0) ? mq1[0] : 19'd0, m_ov1, m_al};
            act_k = {out_valid_k, out_lane_k, out_tag_k, out_data_k, overflow_k, align_err_k};
            act_f = {out_valid_f, out_lane_f, out_tag_f, out_data_f, overflow_f, align_err_f};
            check("model_keep", 32'(act_k), 32'(exp_k));
            check("model_filt", 32'(act_f), 32'(exp_f));
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input bit fs, input logic [3:0] c, input bit ccb,
                        input logic [3:0] r, input bit rcb);
        en = 1'b1; frame_sync = fs;
        col_nib = c; col_ctrl = ccb; row_nib = r; row_ctrl = rcb;
        @(posedge clk); #1;
        en = 1'b0; frame_sync = 1'b0;
    endtask

    task automatic idle(input int n);
        en = 1'b0; frame_sync = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [15:0] first_word;
    int tb_pos;
    bit fsr;

    initial begin
        @(negedge clk);
        check("reset_valid", 32'(out_valid_k), 32'd0);
        check("reset_ovf",   32'(overflow_k), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Eight beats with no sync: everything discarded.
        for (int i = 0; i < 8; i++)
            beat(1'b0, 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
        idle(2);
        @(negedge clk);
        check("presync_valid_k", 32'(out_valid_k), 32'd0);
        check("presync_valid_f", 32'(out_valid_f), 32'd0);
        #1;

        // Basic frame, checked with literal values.
        out_ready = 1'b0;
        beat(1'b1, 4'h1, 1'b0, 4'hA, 1'b0);
        beat(1'b0, 4'h2, 1'b0, 4'hB, 1'b0);
        beat(1'b0, 4'h3, 1'b0, 4'hC, 1'b0);
        beat(1'b0, 4'h4, 1'b0, 4'hD, 1'b0);
        @(negedge clk);
        check("basic_col", {13'd0, out_valid_k, out_lane_k, out_tag_k, out_data_k}, {13'd0, 1'b1, 1'b0, 2'd0, 16'h1234});
        check("basic_filt_empty", 32'(out_valid_f), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("basic_row", {13'd0, out_valid_k, out_lane_k, out_tag_k, out_data_k}, {13'd0, 1'b1, 1'b1, 2'd0, 16'hABCD});
        out_ready = 1'b1;
        idle(3);

        // Readback filter frame: col tag 2 (0xBEEF), row tag 1.
        out_ready = 1'b0;
        beat(1'b1, 4'hB, 1'b1, 4'h9, 1'b0);
        beat(1'b0, 4'hE, 1'b0, 4'h8, 1'b1);
        beat(1'b0, 4'hE, 1'b0, 4'h7, 1'b0);
        beat(1'b0, 4'hF, 1'b1, 4'h6, 1'b1);
        @(negedge clk);
        check("filt_col", {13'd0, out_valid_f, out_lane_f, out_tag_f, out_data_f}, {13'd0, 1'b1, 1'b0, 2'd2, 16'hBEEF});
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("filt_row_dropped", 32'(out_valid_f), 32'd0);
        check("filt_no_ovf", 32'(overflow_f), 32'd0);
        idle(3);

        // Overflow: three frames against a stalled host.
        out_ready = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int b = 0; b < 4; b++)
                beat(b == 0, 4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
            if (f == 0) first_word = 16'(mq0[0] & 19'hFFFF);
        end
        @(negedge clk);
        check("ovf_set", 32'(overflow_k), 32'd1);
        check("ovf_head", 32'(out_data_k), 32'(first_word));
        #1;
        out_ready = 1'b1;
        idle(6);
        clr_flags = 1'b1;
        idle(1);
        clr_flags = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(overflow_k), 32'd0);
        #1;

        // Randomized traffic with back-pressure, en gaps, resyncs and a reset.
        tb_pos = 0;
        for (int c = 0; c < 800; c++) begin
            en = ($urandom % 5) != 0;
            fsr = ((tb_pos == 0) && ($urandom % 10 < 9)) || ($urandom % 40 == 0);
            frame_sync = en && fsr;
            col_nib = 4'($urandom); col_ctrl = 1'($urandom);
            row_nib = 4'($urandom); row_ctrl = 1'($urandom);
            out_ready = ($urandom % 10) < 6;
            clr_flags = ($urandom % 50) == 0;
            @(posedge clk); #1;
            if (en) tb_pos = frame_sync ? 1 : (tb_pos + 1) % 4;
            if (c == 400) begin
                rst_n = 1'b0;
                en = 1'b0; frame_sync = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                tb_pos = 0;
            end
        end
        en = 1'b0; frame_sync = 1'b0; clr_flags = 1'b0; out_ready = 1'b1;
        idle(8);
        @(negedge clk);
        check("final_drained", 32'(out_valid_k), 32'd0);
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
